// File: rtl/branch_predict_resolve.sv
// -----------------------------------------------------------------------------
// branch_predict_resolve
//
// IF-stage branch prediction from a direct-mapped branch target buffer (BTB)
// with saturating counters. EX-stage resolution of conditional, unconditional
// and register jumps, mispredict detection with a registered one-cycle
// redirect, and saturating branch/mispredict statistics.
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   if_pc                 fetch PC to look up
//   pred_taken            BTB predicts taken for if_pc
//   pred_target           predicted target (0 when pred_taken = 0)
//   res_valid             a branch/jump resolves in EX this cycle
//   res_pc                PC of the resolving instruction
//   res_kind              0 ALWAYS,1 JR,2 BEQ,3 BNE,4 BGEZ,5 BGTZ,6 BLTZ,7 BLEZ
//   res_flags             {Z, N} from the ALU
//   res_target            computed branch target
//   res_rs                rs value, used as target for JR
//   res_npc               fall-through PC
//   res_pred_taken        prediction carried down the pipe
//   res_pred_target       predicted target carried down the pipe
//   redirect              one-cycle flush/redirect pulse
//   redirect_pc           corrected PC, valid while redirect = 1
//   branch_cnt            effective resolves, saturating
//   mispred_cnt           mispredicts, saturating
// -----------------------------------------------------------------------------
module branch_predict_resolve #(
    parameter int ADDR_W  = 32,
    parameter int ENTRIES = 16,
    parameter int CTR_W   = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] if_pc,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              res_valid,
    input  logic [ADDR_W-1:0] res_pc,
    input  logic [2:0]        res_kind,
    input  logic [1:0]        res_flags,
    input  logic [ADDR_W-1:0] res_target,
    input  logic [ADDR_W-1:0] res_rs,
    input  logic [ADDR_W-1:0] res_npc,
    input  logic              res_pred_taken,
    input  logic [ADDR_W-1:0] res_pred_target,
    output logic              redirect,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CTR_W-1:0] CTR_MAX  = '1;
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(1) << (CTR_W - 1);

    typedef enum logic [2:0] {
        K_ALWAYS = 3'd0,
        K_JR     = 3'd1,
        K_BEQ    = 3'd2,
        K_BNE    = 3'd3,
        K_BGEZ   = 3'd4,
        K_BGTZ   = 3'd5,
        K_BLTZ   = 3'd6,
        K_BLEZ   = 3'd7
    } kind_e;

    // BTB storage
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_mem [ENTRIES];
    logic [ADDR_W-1:0]  tgt_mem [ENTRIES];
    logic [CTR_W-1:0]   ctr_mem [ENTRIES];

    // ---------------------------------------------------------------- lookup
    logic [IDX_W-1:0] l_idx;
    logic [TAG_W-1:0] l_tag;

    assign l_idx = if_pc[IDX_W+1:2];
    assign l_tag = if_pc[ADDR_W-1:IDX_W+2];

    // Reads the registered table only, so a same-cycle update of this index
    // is seen one cycle later.
    assign pred_taken  = valid_q[l_idx] && (tag_mem[l_idx] == l_tag)
                         && ctr_mem[l_idx][CTR_W-1];
    assign pred_target = pred_taken ? tgt_mem[l_idx] : '0;

    // ------------------------------------------------------------ resolution
    logic              flag_z, flag_n;
    logic              taken;
    logic [ADDR_W-1:0] actual_tgt;
    logic              mispredict;
    logic              eff;
    logic [IDX_W-1:0]  r_idx;
    logic [TAG_W-1:0]  r_tag;
    logic              r_hit;

    assign flag_z = res_flags[1];
    assign flag_n = res_flags[0];

    // NOTE: always_comb gives every output a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        taken = 1'b0;
        case (kind_e'(res_kind))
            K_ALWAYS: taken = 1'b1;
            K_JR:     taken = 1'b1;
            K_BEQ:    taken = flag_z;
            K_BNE:    taken = !flag_z;
            K_BGEZ:   taken = !flag_n;
            K_BGTZ:   taken = !flag_z && !flag_n;
            K_BLTZ:   taken = flag_n;
            K_BLEZ:   taken = flag_z || flag_n;
            default:  taken = 1'b0;
        endcase
    end

    assign actual_tgt = (kind_e'(res_kind) == K_JR) ? res_rs : res_target;
    assign mispredict = (taken != res_pred_taken)
                        || (taken && res_pred_taken && (actual_tgt != res_pred_target));

    // A resolve during the redirect cycle is on the wrong path and is dropped.
    assign eff = res_valid && !redirect;

    assign r_idx = res_pc[IDX_W+1:2];
    assign r_tag = res_pc[ADDR_W-1:IDX_W+2];
    assign r_hit = valid_q[r_idx] && (tag_mem[r_idx] == r_tag);

    // ------------------------------------------------- redirect and counters
    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect    <= 1'b0;
            redirect_pc <= '0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            redirect <= eff && mispredict;
            if (eff && mispredict) begin
                redirect_pc <= taken ? actual_tgt : res_npc;
            end
            if (eff && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + CNT_W'(1);
            end
            if (eff && mispredict && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------ BTB update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (eff && !r_hit && taken) begin
            valid_q[r_idx] <= 1'b1;
        end
    end

    // NOTE: tag/target/counter arrays are not reset; an entry is only
    // meaningful once its valid bit is set, so clearing valid_q suffices.
    always_ff @(posedge clk) begin
        if (eff) begin
            if (r_hit) begin
                if (taken) begin
                    tgt_mem[r_idx] <= actual_tgt;
                    if (ctr_mem[r_idx] != CTR_MAX) begin
                        ctr_mem[r_idx] <= ctr_mem[r_idx] + CTR_W'(1);
                    end
                end else if (ctr_mem[r_idx] != '0) begin
                    ctr_mem[r_idx] <= ctr_mem[r_idx] - CTR_W'(1);
                end
            end else if (taken) begin
                tag_mem[r_idx] <= r_tag;
                tgt_mem[r_idx] <= actual_tgt;
                ctr_mem[r_idx] <= CTR_INIT;
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_resolve.sv
// -----------------------------------------------------------------------------
// tb_branch_predict_resolve
//
// Self-checking bench: directed scenarios followed by randomized traffic,
// all compared against a behavioural BTB/resolve model held in the bench.
// -----------------------------------------------------------------------------
module tb_branch_predict_resolve;

    localparam int ADDR_W  = 32;
    localparam int ENTRIES = 16;
    localparam int CNT_W   = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [31:0]       if_pc;
    logic              pred_taken;
    logic [31:0]       pred_target;
    logic              res_valid;
    logic [31:0]       res_pc;
    logic [2:0]        res_kind;
    logic [1:0]        res_flags;
    logic [31:0]       res_target;
    logic [31:0]       res_rs;
    logic [31:0]       res_npc;
    logic              res_pred_taken;
    logic [31:0]       res_pred_target;
    logic              redirect;
    logic [31:0]       redirect_pc;
    logic [15:0]       branch_cnt;
    logic [15:0]       mispred_cnt;

    branch_predict_resolve #(
        .ADDR_W(ADDR_W), .ENTRIES(ENTRIES), .CTR_W(2), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .res_valid(res_valid), .res_pc(res_pc), .res_kind(res_kind),
        .res_flags(res_flags), .res_target(res_target), .res_rs(res_rs),
        .res_npc(res_npc), .res_pred_taken(res_pred_taken),
        .res_pred_target(res_pred_target), .redirect(redirect),
        .redirect_pc(redirect_pc), .branch_cnt(branch_cnt),
        .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------- model
    // BTB kept as per-slot records; slot = word address mod 16, tag = the
    // remaining upper address bits. Counter kept as a plain integer 0..3.
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    int unsigned m_tgt   [ENTRIES];
    int          m_ctr   [ENTRIES];
    bit          m_redirect;
    int unsigned m_rpc;
    int unsigned m_bcnt, m_mcnt;

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
        m_redirect = 0;
        m_rpc      = 0;
        m_bcnt     = 0;
        m_mcnt     = 0;
    endfunction

    function automatic void model_lookup(input int unsigned pc, output bit t,
                                         output int unsigned tg);
        int unsigned slot = (pc / 4) % ENTRIES;
        int unsigned tagv = pc / (4 * ENTRIES);
        t  = m_valid[slot] && (m_tag[slot] == tagv) && (m_ctr[slot] >= 2);
        tg = t ? m_tgt[slot] : 0;
    endfunction

    function automatic bit cond_taken(input int kind, input bit z, input bit n);
        case (kind)
            0, 1:    return 1;
            2:       return z;
            3:       return !z;
            4:       return !n;
            5:       return !z && !n;
            6:       return n;
            default: return z || n;
        endcase
    endfunction

    // Advance the model by one clock using the current inputs.
    function automatic void model_clock();
        bit          eff = res_valid && !m_redirect;
        bit          tk  = cond_taken(int'(res_kind), res_flags[1], res_flags[0]);
        int unsigned act = (res_kind == 3'd1) ? res_rs : res_target;
        bit          mis = (tk != res_pred_taken) ||
                           (tk && res_pred_taken && act != res_pred_target);
        int unsigned slot = (res_pc / 4) % ENTRIES;
        int unsigned tagv = res_pc / (4 * ENTRIES);
        m_redirect = eff && mis;
        if (eff && mis) m_rpc = tk ? act : res_npc;
        if (eff && m_bcnt < 65535) m_bcnt++;
        if (eff && mis && m_mcnt < 65535) m_mcnt++;
        if (eff) begin
            if (m_valid[slot] && m_tag[slot] == tagv) begin
                if (tk) begin
                    m_tgt[slot] = act;
                    m_ctr[slot] = (m_ctr[slot] < 3) ? m_ctr[slot] + 1 : 3;
                end else begin
                    m_ctr[slot] = (m_ctr[slot] > 0) ? m_ctr[slot] - 1 : 0;
                end
            end else if (tk) begin
                m_valid[slot] = 1;
                m_tag[slot]   = tagv;
                m_tgt[slot]   = act;
                m_ctr[slot]   = 2;
            end
        end
    endfunction

    // One clock: check lookup before the edge, then registered outputs after.
    task automatic step();
        bit          et;
        int unsigned etg;
        #1;
        model_lookup(if_pc, et, etg);
        check("pred_taken", 64'(pred_taken), 64'(et));
        check("pred_target", 64'(pred_target), 64'(etg));
        model_clock();
        @(posedge clk);
        #1;
        check("redirect", 64'(redirect), 64'(m_redirect));
        if (m_redirect) check("redirect_pc", 64'(redirect_pc), 64'(m_rpc));
        check("branch_cnt", 64'(branch_cnt), 64'(m_bcnt));
        check("mispred_cnt", 64'(mispred_cnt), 64'(m_mcnt));
    endtask

    task automatic resolve(input logic [31:0] pc, input logic [2:0] kind,
                           input logic [1:0] flags, input logic [31:0] tgt,
                           input logic [31:0] npc, input logic [31:0] rs,
                           input logic pt, input logic [31:0] ptg);
        res_valid = 1; res_pc = pc; res_kind = kind; res_flags = flags;
        res_target = tgt; res_npc = npc; res_rs = rs;
        res_pred_taken = pt; res_pred_target = ptg;
        step();
        res_valid = 0;
    endtask

    task automatic idle();
        res_valid = 0;
        step();
    endtask

    int unsigned save_b, save_m;

    initial begin
        reset = 1; if_pc = 0; res_valid = 0; res_pc = 0; res_kind = 0;
        res_flags = 0; res_target = 0; res_rs = 0; res_npc = 0;
        res_pred_taken = 0; res_pred_target = 0;
        model_reset();
        #12;
        check("rst_redirect", 64'(redirect), 64'd0);
        check("rst_redirect_pc", 64'(redirect_pc), 64'd0);
        check("rst_branch_cnt", 64'(branch_cnt), 64'd0);
        check("rst_mispred_cnt", 64'(mispred_cnt), 64'd0);
        @(negedge clk);
        reset = 0;

        // 1. cold miss, BEQ taken, allocate
        if_pc = 32'h40;
        #1 check("cold_pred", 64'(pred_taken), 64'd0);
        resolve(32'h40, 3'd2, 2'b10, 32'h80, 32'h48, 32'h0, 1'b0, 32'h0);
        check("t1_redirect", 64'(redirect), 64'd1);
        check("t1_redirect_pc", 64'(redirect_pc), 64'h80);
        check("t1_mispred", 64'(mispred_cnt), 64'd1);
        check("t1_branch", 64'(branch_cnt), 64'd1);
        idle();
        #1 check("t1_pred_taken", 64'(pred_taken), 64'd1);
        check("t1_pred_target", 64'(pred_target), 64'h80);

        // 2. hysteresis: saturate, one not-taken still predicts taken
        resolve(32'h40, 3'd2, 2'b10, 32'h80, 32'h48, 32'h0, 1'b1, 32'h80);
        resolve(32'h40, 3'd2, 2'b10, 32'h80, 32'h48, 32'h0, 1'b1, 32'h80);
        resolve(32'h40, 3'd2, 2'b00, 32'h80, 32'h48, 32'h0, 1'b1, 32'h80);
        check("t2_nt_redirect_pc", 64'(redirect_pc), 64'h48);
        idle();
        #1 check("t2_still_taken", 64'(pred_taken), 64'd1);
        resolve(32'h40, 3'd2, 2'b00, 32'h80, 32'h48, 32'h0, 1'b1, 32'h80);
        idle();
        #1 check("t2_now_not_taken", 64'(pred_taken), 64'd0);

        // 3. alias at same index, different tag
        if_pc = 32'h440;
        #1 check("t3_alias_miss", 64'(pred_taken), 64'd0);
        resolve(32'h440, 3'd0, 2'b00, 32'h900, 32'h444, 32'h0, 1'b0, 32'h0);
        idle();
        #1 check("t3_alias_hit", 64'(pred_target), 64'h900);
        if_pc = 32'h40;
        #1 check("t3_old_miss", 64'(pred_taken), 64'd0);

        // 4. JR target mispredict
        save_m = m_mcnt;
        resolve(32'h84, 3'd1, 2'b00, 32'h0, 32'h88, 32'h12345678, 1'b1, 32'h100);
        check("t4_redirect_pc", 64'(redirect_pc), 64'h12345678);
        check("t4_mispred", 64'(mispred_cnt), 64'(save_m + 1));
        idle();

        // 5. conditions and squash
        resolve(32'h88, 3'd5, 2'b11, 32'h200, 32'h8c, 32'h0, 1'b0, 32'h0);
        check("t5_bgtz_nt", 64'(redirect), 64'd0);
        resolve(32'h8c, 3'd4, 2'b01, 32'h200, 32'h90, 32'h0, 1'b0, 32'h0);
        check("t5_bgez_nt", 64'(redirect), 64'd0);
        resolve(32'h90, 3'd0, 2'b00, 32'h300, 32'h94, 32'h0, 1'b0, 32'h0);
        save_b = m_bcnt; save_m = m_mcnt;
        resolve(32'h94, 3'd0, 2'b00, 32'h400, 32'h98, 32'h0, 1'b0, 32'h0);
        check("t5_squash_redirect", 64'(redirect), 64'd0);
        check("t5_squash_bcnt", 64'(branch_cnt), 64'(save_b));
        check("t5_squash_mcnt", 64'(mispred_cnt), 64'(save_m));

        // 6. async reset while redirect is high
        resolve(32'h40, 3'd0, 2'b00, 32'h80, 32'h44, 32'h0, 1'b0, 32'h0);
        check("t6_pre_redirect", 64'(redirect), 64'd1);
        #2 reset = 1;
        #1;
        check("t6_async_redirect", 64'(redirect), 64'd0);
        check("t6_async_bcnt", 64'(branch_cnt), 64'd0);
        check("t6_async_mcnt", 64'(mispred_cnt), 64'd0);
        model_reset();
        @(negedge clk);
        reset = 0;
        if_pc = 32'h40;
        #1 check("t6_pred_cleared", 64'(pred_taken), 64'd0);
        idle();

        // Randomized traffic over a small PC space to exercise hits/aliases
        for (int n = 0; n < 600; n++) begin
            bit          pt;
            int unsigned ptg;
            if_pc     = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            res_valid = ($urandom_range(0, 9) < 7);
            res_pc    = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
            res_kind  = 3'($urandom_range(0, 7));
            res_flags = 2'($urandom_range(0, 3));
            res_target = {$urandom_range(0, 3), 2'b00} + 32'h1000;
            res_rs     = {$urandom_range(0, 3), 2'b00} + 32'h2000;
            res_npc    = res_pc + 4;
            if ($urandom_range(0, 9) < 6) begin
                model_lookup(res_pc, pt, ptg);
            end else begin
                pt  = 1'($urandom_range(0, 1));
                ptg = {$urandom_range(0, 3), 2'b00} + 32'h1000;
            end
            res_pred_taken  = pt;
            res_pred_target = ptg;
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predict_resolve.md
Name: branch_predict_resolve

Overview:
- Parametrised successor to the branch condition/target selection logic.
- Adds a direct-mapped branch target buffer (BTB) with saturating counters for IF-stage prediction.
- Resolves conditional/unconditional/register jumps in EX from Z/N flags, detects mispredicts and issues a registered one-cycle redirect to the PC mux.
- Keeps saturating branch/mispredict statistics.

Parameters:
- ADDR_W, 32, PC/target width.
- ENTRIES, 16, BTB entries; power of 2, ≥2. IDX_W = log2(ENTRIES).
- CTR_W, 2, prediction counter width.
- CNT_W, 16, statistic counter width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- if_pc  in  ADDR_W  fetch PC.
- pred_taken  out  1  BTB prediction for if_pc.
- pred_target  out  ADDR_W  predicted target (0 when pred_taken=0).
- res_valid  in  1  branch/jump resolving in EX this cycle.
- res_pc  in  ADDR_W  PC of resolving instruction.
- res_kind  in  3  0 ALWAYS, 1 JR, 2 BEQ, 3 BNE, 4 BGEZ, 5 BGTZ, 6 BLTZ, 7 BLEZ.
- res_flags  in  2  {Z,N} from ALU.
- res_target  in  ADDR_W  computed TA (PC+4+imm or concatenation).
- res_rs  in  ADDR_W  rs value for JR.
- res_npc  in  ADDR_W  fall-through PC.
- res_pred_taken  in  1  prediction carried down the pipe.
- res_pred_target  in  ADDR_W  predicted target carried down the pipe.
- redirect  out  1  one-cycle flush/redirect pulse.
- redirect_pc  out  ADDR_W  corrected PC, valid while redirect=1.
- branch_cnt  out  CNT_W  resolved branches, saturating.
- mispred_cnt  out  CNT_W  mispredicts, saturating.

Behaviour:
- Reset (async): all BTB valid bits cleared; redirect=0, redirect_pc=0, branch_cnt=0, mispred_cnt=0. Reset mid-operation drops any pending redirect immediately.
- Lookup (combinational from registered table):
  - idx = if_pc[IDX_W+1:2], tag = if_pc[ADDR_W-1:IDX_W+2].
  - pred_taken = valid & tag match & ctr MSB.
  - pred_target = stored target when pred_taken=1, else 0.
- Condition (Z = res_flags[1], N = res_flags[0]):
  - ALWAYS, JR: taken.
  - BEQ: Z. BNE: !Z. BGEZ: !N. BGTZ: !Z & !N. BLTZ: N. BLEZ: Z | N.
- Actual target: res_rs for JR, res_target otherwise.
- Effective resolve: eff = res_valid & !redirect. A resolve arriving in the redirect cycle is wrong-path and is fully ignored: no table, counter or redirect effect.
- Mispredict = (taken != res_pred_taken) | (taken & res_pred_taken & target != res_pred_target).
- On eff with mispredict, next edge:
  - redirect = 1.
  - redirect_pc = taken ? actual target : res_npc.
- Otherwise redirect = 0 next edge; redirect is never high for two consecutive cycles.
- BTB update on eff, using res_pc index/tag:
  - Hit: counter +1 if taken, −1 if not; saturate at 0 and 2^CTR_W−1. Target overwritten when taken.
  - Miss and taken: allocate (replace). Set valid, tag and target; counter = 2^(CTR_W−1) (weakly taken).
  - Miss and not taken: no change.
- Same-cycle lookup and update of the same index: lookup returns the pre-update value.
- Statistics:
  - branch_cnt +1 per eff.
  - mispred_cnt +1 per eff with mispredict.
  - Both hold at all-ones.

Test Plan:
1. Cold miss: reset; if_pc=0x40 → pred_taken=0. Resolve BEQ at 0x40 with flags=10, res_target=0x80, res_npc=0x48, res_pred_taken=0 → next cycle redirect=1, redirect_pc=0x80, mispred_cnt=1, branch_cnt=1. Then if_pc=0x40 → pred_taken=1, pred_target=0x80.
2. Hysteresis: at 0x40, two more taken resolves (counter 11), then one not-taken → still predicts taken. Second not-taken → pred_taken=0. The not-taken mispredict redirects to res_npc=0x48.
3. Alias: after entry for 0x40 exists, if_pc=0x440 (same index 0, different tag) → pred_taken=0. Taken resolve at 0x440 replaces the entry; 0x40 then misses.
4. JR target mispredict: kind=1, res_rs=0x12345678, res_pred_taken=1, res_pred_target=0x100 → redirect=1, redirect_pc=0x12345678, mispred_cnt increments.
5. Conditions and squash:
   - BGTZ with flags=11 → not taken.
   - BGEZ with flags=01 → not taken.
   - A res_valid asserted in the redirect cycle → no redirect next cycle, counters unchanged.
6. Async reset while redirect=1 → redirect=0 and counters=0 immediately, before the next clk edge. Previously trained if_pc=0x40 → pred_taken=0.
